// File: rtl/parity_serial_rx_if.sv
// Output stream of the parity-checked serial receiver: received word, error
// flags and overrun strobe, with the word handed over on a valid/ready handshake.
interface parity_serial_rx_if #(
  parameter int N_DATA = 8
);
  logic [N_DATA-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;

  modport master (
    output m_data, m_valid, parity_err, frame_err, overrun,
    input  m_ready
  );

  modport slave (
    input  m_data, m_valid, parity_err, frame_err, overrun,
    output m_ready
  );
endinterface

// File: rtl/parity_serial_rx.sv
// Parity-protected async serial receiver: start, N_DATA bits LSB first, parity,
// stop; each frame lands in a one-deep valid/ready output register.
module parity_serial_rx #(
  parameter int N_DATA       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic               p_type,
  output logic               busy,
  parity_serial_rx_if.master m_if
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (N_DATA > 1) ? $clog2(N_DATA) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(N_DATA - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e            state;
  state_e            state_d;
  logic              rx_meta;
  logic              rx_s;
  logic              rx_prev;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_idx;
  logic [N_DATA-1:0] shift;
  logic              ptype_lat;
  logic              par_acc;
  logic              perr_q;
  logic              tick;
  logic              start_edge;
  logic              confirm;
  logic              frame_done;
  logic              slot_free;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign start_edge = rx_prev & ~rx_s;

  always_comb begin
    // NOTE: every signal gets its default before the case, so no path leaves it unassigned and no latch is inferred.
    state_d = state;
    tick    = (state == S_START) ? (cnt == HALF_LAST) : (cnt == BIT_LAST);
    case (state)
      S_IDLE:   if (start_edge) state_d = S_START;
      S_START:  if (tick) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (tick && bit_idx == DATA_LAST) state_d = S_PARITY;
      S_PARITY: if (tick) state_d = S_STOP;
      S_STOP:   if (tick) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values, whatever the statement order.
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  assign confirm    = (state == S_START) && tick && !rx_s;
  assign frame_done = (state == S_STOP) && tick;
  assign slot_free  = !m_if.m_valid || m_if.m_ready;
  assign busy       = (state != S_IDLE);

  // Counter restarts on every sample point, so the next one lands a full bit later.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      bit_idx   <= '0;
      ptype_lat <= 1'b0;
      par_acc   <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      if (state == S_IDLE || tick) cnt <= '0;
      else                         cnt <= cnt + 1'b1;

      if (state == S_IDLE)             bit_idx <= '0;
      else if (state == S_DATA && tick) bit_idx <= bit_idx + 1'b1;

      if (confirm) begin
        ptype_lat <= p_type;
        par_acc   <= 1'b0;
      end
      if (state == S_DATA && tick)   par_acc <= par_acc ^ rx_s;
      if (state == S_PARITY && tick) perr_q  <= (par_acc ^ rx_s) != ~ptype_lat;
    end
  end

  // NOTE: the data shift register has no reset; every bit is rewritten in each frame before it can reach m_data.
  always_ff @(posedge clk) begin
    if (state == S_DATA && tick) shift[bit_idx] <= rx_s;
  end

  // Output slot: load on frame end if free, otherwise drop the frame and flag overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_if.m_data     <= '0;
      m_if.m_valid    <= 1'b0;
      m_if.parity_err <= 1'b0;
      m_if.frame_err  <= 1'b0;
      m_if.overrun    <= 1'b0;
    end else begin
      m_if.overrun <= frame_done && !slot_free;
      if (frame_done && slot_free) begin
        m_if.m_data     <= shift;
        m_if.parity_err <= perr_q;
        m_if.frame_err  <= ~rx_s;
        m_if.m_valid    <= 1'b1;
      end else if (m_if.m_valid && m_if.m_ready) begin
        m_if.m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_parity_serial_rx.sv
// Bench for parity_serial_rx: directed frames with literal expectations plus a
// randomized run, all checked every cycle against a frame-level delivery model.
module tb_parity_serial_rx;

  localparam int N     = 8;
  localparam int CPB   = 16;
  localparam int H     = CPB / 2;
  localparam int FRAME = (N + 3) * CPB;
  // Cycle in which rx_in first goes low -> cycle in which m_valid rises.
  localparam int LAT   = 2 + H + (N + 2) * CPB + 1;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic rx_in  = 1'b1;
  logic p_type = 1'b0;
  logic busy;

  parity_serial_rx_if #(.N_DATA(N)) bus ();

  parity_serial_rx #(.N_DATA(N), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_in (rx_in),
    .p_type(p_type),
    .busy  (busy),
    .m_if  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int           due;
    logic [N-1:0] data;
    logic         perr;
    logic         ferr;
  } frame_t;

  frame_t exp_q[$];

  // Busy window of the most recent start (inclusive cycles).
  int bw_lo = 0;
  int bw_hi = -1;

  // Consumer: 0 stalled, 1 always ready, 2 mostly ready, 3 rarely ready.
  int ready_mode = 1;
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.m_ready = 1'b0;
        1:       bus.m_ready = 1'b1;
        2:       bus.m_ready = ($urandom_range(0, 3) != 0);
        default: bus.m_ready = ($urandom_range(0, 9) == 0);
      endcase
    end
  end

  function automatic logic good_parity(input logic [N-1:0] d, input logic pt);
    int ones;
    ones = $countones(d);
    return pt ? ((ones % 2) == 1) : ((ones % 2) == 0);
  endfunction

  function automatic logic parity_bad(input logic [N-1:0] d, input logic pbit, input logic pt);
    int total;
    total = $countones(d) + int'(pbit);
    return pt ? ((total % 2) == 1) : ((total % 2) == 0);
  endfunction

  // Model of the output slot, advanced once per cycle from frame due times.
  logic         ev = 1'b0, ep = 1'b0, ef = 1'b0, eo = 1'b0, eb = 1'b0, hs = 1'b0;
  logic [N-1:0] ed = '0;
  logic         rst_prev = 1'b1;
  logic         ready_prev = 1'b0;
  int           rd_idx = 0;
  int           last_rst = -1;

  always @(negedge clk) begin
    if (rst_prev) begin
      ev = 1'b0; ed = '0; ep = 1'b0; ef = 1'b0; eo = 1'b0;
      rd_idx   = exp_q.size();
      last_rst = cyc;
    end else begin
      hs = ev && ready_prev;
      eo = 1'b0;
      if (rd_idx < exp_q.size() && exp_q[rd_idx].due == cyc) begin
        if (!ev || hs) begin
          ev = 1'b1;
          ed = exp_q[rd_idx].data;
          ep = exp_q[rd_idx].perr;
          ef = exp_q[rd_idx].ferr;
        end else begin
          eo = 1'b1;
        end
        rd_idx++;
      end else if (hs) begin
        ev = 1'b0;
      end
    end
    eb = (cyc >= bw_lo) && (cyc <= bw_hi) && (bw_lo > last_rst);
    if (cyc >= 1) begin
      check("m_valid", bus.m_valid, ev);
      check("overrun", bus.overrun, eo);
      check("busy", busy, eb);
      if (ev) begin
        check("m_data", bus.m_data, ed);
        check("parity_err", bus.parity_err, ep);
        check("frame_err", bus.frame_err, ef);
      end
    end
    rst_prev   = rst;
    ready_prev = bus.m_ready;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_cycle(input int k);
    while (!(cyc >= k && clk == 1'b0)) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) step();
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (CPB) step();
  endtask

  task automatic send_frame(input logic [N-1:0] d, input logic pt, input logic pbit, input logic stop);
    frame_t f;
    f.due  = cyc + LAT;
    f.data = d;
    f.perr = parity_bad(d, pbit, pt);
    f.ferr = ~stop;
    exp_q.push_back(f);
    bw_lo  = cyc + 3;
    bw_hi  = cyc + LAT - 1;
    p_type = pt;
    drive_bit(1'b0);
    for (int i = 0; i < N; i++) drive_bit(d[i]);
    drive_bit(pbit);
    drive_bit(stop);
  endtask

  task automatic glitch(input int len);
    bw_lo = cyc + 3;
    bw_hi = cyc + 2 + H;
    rx_in = 1'b0;
    repeat (len) step();
    rx_in = 1'b1;
    repeat (CPB) step();
  endtask

  task automatic send_pinned(input string tag, input logic [N-1:0] d, input logic pt,
                             input logic pbit, input logic stop,
                             input logic exp_perr, input logic exp_ferr);
    int d_at;
    d_at = cyc + LAT;
    fork
      send_frame(d, pt, pbit, stop);
      begin
        at_cycle(d_at - 1);
        check({tag, "_pre_valid"}, bus.m_valid, 0);
        at_cycle(d_at);
        check({tag, "_valid"}, bus.m_valid, 1);
        check({tag, "_data"}, bus.m_data, d);
        check({tag, "_parity_err"}, bus.parity_err, exp_perr);
        check({tag, "_frame_err"}, bus.frame_err, exp_ferr);
        at_cycle(d_at + 1);
        check({tag, "_post_valid"}, bus.m_valid, 0);
      end
    join
  endtask

  initial begin
    int c;
    int d1;
    int d2;
    logic [N-1:0] rd;
    logic rpt, rpb, rsb;
    int gap;

    step(); step(); step();
    @(negedge clk);
    check("rst_valid", bus.m_valid, 0);
    check("rst_data", bus.m_data, 0);
    check("rst_parity_err", bus.parity_err, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_busy", busy, 0);
    step();
    rst = 1'b0;
    idle(5);

    // Clean frame, even parity.
    send_pinned("t1", 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // Parity errors and a clean odd-parity frame.
    send_pinned("t2a", 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    send_pinned("t2b", 8'h07, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_pinned("t2c", 8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    // Stop bit low.
    send_pinned("t3", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);

    // False start: short low pulse.
    c = cyc;
    fork
      glitch(4);
      begin
        at_cycle(c + 10);
        check("t4_busy_hi", busy, 1);
        at_cycle(c + 11);
        check("t4_busy_lo", busy, 0);
        check("t4_no_valid", bus.m_valid, 0);
      end
    join
    idle(4);

    // Stalled consumer, two frames back to back.
    ready_mode = 0;
    c  = cyc;
    d1 = c + LAT;
    d2 = d1 + FRAME;
    fork
      begin
        send_frame(8'h11, 1'b1, 1'b0, 1'b1);
        send_frame(8'h22, 1'b1, 1'b0, 1'b1);
      end
      begin
        at_cycle(d1);
        check("t5_first_valid", bus.m_valid, 1);
        check("t5_first_data", bus.m_data, 8'h11);
        check("t5_first_overrun", bus.overrun, 0);
        at_cycle(d2);
        check("t5_overrun", bus.overrun, 1);
        check("t5_hold_data", bus.m_data, 8'h11);
        check("t5_hold_valid", bus.m_valid, 1);
        at_cycle(d2 + 1);
        check("t5_overrun_end", bus.overrun, 0);
        check("t5_still_data", bus.m_data, 8'h11);
      end
    join
    ready_mode = 1;
    @(negedge clk);
    check("t5_accept_valid", bus.m_valid, 1);
    @(negedge clk);
    check("t5_cleared", bus.m_valid, 0);
    step();
    idle(4);

    // Reset in the middle of data bit 3, then a clean frame.
    c     = cyc;
    bw_lo = c + 3;
    bw_hi = c + 100000;
    rd    = 8'hC3;
    p_type = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(rd[i]);
    rx_in = rd[3];
    repeat (H) step();
    rst   = 1'b1;
    rx_in = 1'b1;
    @(negedge clk);
    check("t6_busy_before", busy, 1);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_valid", bus.m_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_data", bus.m_data, 0);
    check("t6_overrun", bus.overrun, 0);
    check("t6_parity_err", bus.parity_err, 0);
    check("t6_frame_err", bus.frame_err, 0);
    step();
    idle(20);
    send_pinned("t6", 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Randomized traffic with varying consumer readiness and stray glitches.
    for (int i = 0; i < 24; i++) begin
      ready_mode = (i < 12) ? 2 : 3;
      rd  = N'($urandom);
      rpt = 1'($urandom_range(0, 1));
      rpb = good_parity(rd, rpt) ^ ($urandom_range(0, 3) == 0);
      rsb = ($urandom_range(0, 5) != 0);
      send_frame(rd, rpt, rpb, rsb);
      gap = rsb ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12));
      idle(gap);
      if ($urandom_range(0, 4) == 0) glitch(int'($urandom_range(1, H - 1)));
    end

    ready_mode = 1;
    idle(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
